// File: rtl/isrt_norm_sched.sv
// Sequencer for the shared inv_sqrt: variance RAM -> inv_sqrt -> coef RAM, one op in flight, 3+L+1 cycles/element.
// start ignored while busy or draining after rst; inv_sqrt stalls capped at TIMEOUT; ISRT_MINCLAMP_EN clamps var<1.0 instead of skipping.
module isrt_norm_sched #(
  parameter int IBIT    = 32,
  parameter int OBIT    = 11,
  parameter int AW      = 5,
  parameter int TIMEOUT = 63
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   dims,
  output logic [AW-1:0]   var_addr,
  output logic            var_rd,
  input  logic [IBIT-1:0] var_data,
  output logic [IBIT-1:0] sq_o,
  output logic            isrt_go,
  input  logic            isrt_dv,
  input  logic [OBIT-1:0] isrt_val,
  output logic            coef_we,
  output logic [AW-1:0]   coef_addr,
  output logic [OBIT-1:0] coef_data,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IBIT-1:0] SQ_ONE = IBIT'(1024);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LAT, S_GO, S_WAIT, S_WR, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   idx, idx_n;
  logic [AW-1:0]   dims_q, dims_n;
  logic [AW-1:0]   caddr_n;
  logic [OBIT-1:0] cdata_n;
  logic [IBIT-1:0] sq_n;
  logic [CW-1:0]   wcnt, wcnt_n;
  logic [CW-1:0]   drain, drain_n;
  logic            err_n;

  assign var_addr = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      dims_q    <= '0;
      sq_o      <= '0;
      wcnt      <= '0;
      drain     <= CW'(TIMEOUT);
      err       <= 1'b0;
      coef_addr <= '0;
      coef_data <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      dims_q    <= dims_n;
      sq_o      <= sq_n;
      wcnt      <= wcnt_n;
      drain     <= drain_n;
      err       <= err_n;
      coef_addr <= caddr_n;
      coef_data <= cdata_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    dims_n  = dims_q;
    sq_n    = sq_o;
    wcnt_n  = wcnt;
    err_n   = err;
    caddr_n = coef_addr;
    cdata_n = coef_data;
    // an op abandoned by rst may still be running inside inv_sqrt; let it finish first
    drain_n = (drain != '0) ? drain - CW'(1) : drain;
    var_rd  = 1'b0;
    isrt_go = 1'b0;
    coef_we = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && drain == '0) begin
          err_n = 1'b0;
          if (dims != '0) begin
            dims_n  = dims;
            idx_n   = '0;
            state_n = S_RD;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_RD: begin
        busy    = 1'b1;
        var_rd  = 1'b1;
        state_n = S_LAT;
      end
      S_LAT: begin
        busy = 1'b1;
`ifdef ISRT_MINCLAMP_EN
        sq_n    = (var_data < SQ_ONE) ? SQ_ONE : var_data;
        state_n = S_GO;
`else
        // below 1.0 is outside inv_sqrt's range: write 1.0 and flag it
        if (var_data < SQ_ONE) begin
          caddr_n = idx;
          cdata_n = OBIT'(1024);
          err_n   = 1'b1;
          state_n = S_WR;
        end else begin
          sq_n    = var_data;
          state_n = S_GO;
        end
`endif
      end
      S_GO: begin
        busy    = 1'b1;
        isrt_go = 1'b1;
        wcnt_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (isrt_dv) begin
          caddr_n = idx;
          cdata_n = isrt_val;
          state_n = S_WR;
        end else if (wcnt == CW'(TIMEOUT - 1)) begin
          caddr_n = idx;
          cdata_n = '0;
          err_n   = 1'b1;
          state_n = S_WR;
        end else begin
          wcnt_n = wcnt + CW'(1);
        end
      end
      S_WR: begin
        busy    = 1'b1;
        coef_we = 1'b1;
        if (idx == dims_q - AW'(1)) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + AW'(1);
          state_n = S_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule
